// File: rtl/vj_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// The line output is registered, so tx trails the FSM state by one clock.
module vj_uart_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CPB - 1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic push_s;
  logic pop_s;
  logic empty_s;
  logic baud_end_s;

  assign empty_s    = (count_q == {CNTW{1'b0}});
  assign push_s     = in_valid && (count_q != CNT_FULL);
  assign baud_end_s = (baud_q == BAUD_LAST);

  assign in_ready   = (count_q != CNT_FULL);
  assign busy       = (state_q != S_IDLE) || !empty_s;
  assign fifo_count = count_q;
  assign tx         = tx_q;

  // Frame sequencing: the head of the FIFO is popped into the shifter when idle
  // or at the end of a stop bit, so a continuous stream has no idle gap.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_q];
          baud_d  = {CW{1'b0}};
          state_d = S_START;
        end else begin
          baud_d  = {CW{1'b0}};
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_end_s) begin
          baud_d  = {CW{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_end_s) begin
          baud_d  = {CW{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end_s) begin
          baud_d = {CW{1'b0}};
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = {CW{1'b0}};
      end
    endcase
  end

  // FIFO pointer/occupancy next state; a push and pop on one edge cancel out.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_s) begin
      wr_d = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // State, counter and line registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      baud_q  <= {CW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      count_q <= {CNTW{1'b0}};
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_vj_uart_tx.sv
// Scoreboarded bench for vj_uart_tx: bytes are queued when accepted and a
// serial decoder on tx pops and compares them frame by frame.
module tb_vj_uart_tx;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * CPB;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  vj_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  bit         mon_act = 1'b0;

  // Serial decoder: samples mid-bit on falling edges, one frame at a time.
  initial begin
    int         mcnt;
    logic [7:0] mbyte;
    logic [7:0] want;
    mcnt = 0;
    mbyte = 8'h00;
    forever begin
      @(negedge clk);
      if (areset) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1'b1;
          mcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
        if (mcnt == CPB / 2) begin
          n_tests++;
          if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL start_bit: tx=%b required 0 at cycle %0d", tx, cyc);
          end
        end else if (mcnt >= CPB + CPB / 2 && mcnt < 9 * CPB && (mcnt - CPB - CPB / 2) % CPB == 0) begin
          mbyte[3'((mcnt - CPB - CPB / 2) / CPB)] = tx;
        end else if (mcnt == 9 * CPB + CPB / 2) begin
          n_tests++;
          if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_bit: tx=%b required 1 at cycle %0d", tx, cyc);
          end
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_data: decoded %h required no frame", mbyte);
          end else begin
            want = exp_q.pop_front();
            if (mbyte !== want) begin
              n_fail++;
              $display("FAIL frame_data: decoded %h required %h", mbyte, want);
            end
          end
        end
        if (mcnt == FRAME - 1) mon_act = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy !== 1'b0 || mon_act || exp_q.size() != 0) && k < 2000) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 2000) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b pending=%0d required idle within 2000 cycles", tag, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int e;
    int s0;
    s0 = starts.size();
    in_data = 8'hA5;
    in_valid = 1'b1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", in_ready); end
    tick();
    e = cyc;
    in_valid = 1'b0;
    exp_q.push_back(8'hA5);
    n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d required 1", fifo_count); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy); end
    tick();
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_e1: got %b required 1", tx); end
    tick();
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL single_tx_e2: got %b required 0", tx); end
    repeat (FRAME - 2) tick();
    n_tests++; if (busy !== 1'b1 || tx !== 1'b1) begin n_fail++; $display("FAIL single_stop: busy=%b tx=%b required 1 1", busy, tx); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b required 0", busy); end
    wait_idle("single");
    n_tests++;
    if (starts.size() != s0 + 1 || starts[s0] != e + 2) begin
      n_fail++;
      $display("FAIL single_start_time: frames=%0d start=%0d required 1 frame at %0d", starts.size() - s0, (starts.size() > s0) ? starts[s0] : -1, e + 2);
    end
  endtask

  task automatic test_burst();
    logic [7:0] b[6];
    int         ec[5];
    int         s0;
    int         k;
    b = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'hAA, 8'h33};
    ec = '{1, 1, 2, 3, 4};
    s0 = starts.size();
    for (int i = 0; i < 5; i++) begin
      in_data = b[i];
      in_valid = 1'b1;
      tick();
      exp_q.push_back(b[i]);
      n_tests++; if (fifo_count !== 3'(ec[i])) begin n_fail++; $display("FAIL burst_count%0d: got %0d required %0d", i, fifo_count, ec[i]); end
    end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL burst_full_ready: got %b required 0", in_ready); end
    in_data = b[5];
    k = 0;
    while (in_ready !== 1'b1 && k < 300) begin tick(); k++; end
    n_tests++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL burst_resume: in_ready=%b required 1 within 300 cycles", in_ready);
    end else begin
      tick();
      exp_q.push_back(b[5]);
    end
    in_valid = 1'b0;
    wait_idle("burst");
    n_tests++;
    if (starts.size() != s0 + 6) begin
      n_fail++;
      $display("FAIL burst_frames: got %0d required 6", starts.size() - s0);
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_tests++;
        if (starts[s0 + i] - starts[s0 + i - 1] != FRAME) begin
          n_fail++;
          $display("FAIL burst_gap%0d: got %0d required %0d", i, starts[s0 + i] - starts[s0 + i - 1], FRAME);
        end
      end
    end
  endtask

  task automatic test_full_hold();
    int p0;
    int bad;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h10 + 8'(i);
      in_valid = 1'b1;
      tick();
      if (i == 0) p0 = cyc;
      exp_q.push_back(8'h10 + 8'(i));
    end
    in_data = 8'h77;
    bad = 0;
    while (cyc < p0 + FRAME) begin
      tick();
      if (fifo_count !== 3'd4 || in_ready !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL full_hold: %0d cycles with count/ready changed required 0", bad); end
    tick();
    n_tests++; if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop: count=%0d ready=%b required 3 1", fifo_count, in_ready); end
    tick();
    exp_q.push_back(8'h77);
    in_valid = 1'b0;
    n_tests++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_refill: count=%0d ready=%b required 4 0", fifo_count, in_ready); end
    wait_idle("full");
  endtask

  task automatic test_reset_mid();
    int p0;
    int e;
    int s0;
    logic [7:0] b[3];
    b = '{8'h3C, 8'h11, 8'h22};
    for (int i = 0; i < 3; i++) begin
      in_data = b[i];
      in_valid = 1'b1;
      tick();
      if (i == 0) p0 = cyc;
      exp_q.push_back(b[i]);
    end
    in_valid = 1'b0;
    while (cyc < p0 + 40) tick();
    n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL rmid_queued: got %0d required 2", fifo_count); end
    areset = 1'b1;
    tick();
    exp_q.delete();
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b required 1", tx); end
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d required 0", fifo_count); end
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_flags: busy=%b ready=%b required 0 1", busy, in_ready); end
    areset = 1'b0;
    tick();
    n_tests++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet: tx=%b busy=%b required 1 0", tx, busy); end
    s0 = starts.size();
    in_data = 8'h81;
    in_valid = 1'b1;
    tick();
    e = cyc;
    in_valid = 1'b0;
    exp_q.push_back(8'h81);
    wait_idle("rmid");
    n_tests++;
    if (starts.size() != s0 + 1 || starts[s0] != e + 2) begin
      n_fail++;
      $display("FAIL rmid_restart: frames=%0d start=%0d required 1 frame at %0d", starts.size() - s0, (starts.size() > s0) ? starts[s0] : -1, e + 2);
    end
  endtask

  task automatic test_push_at_stop();
    int p0;
    int s0;
    s0 = starts.size();
    in_data = 8'hA1;
    in_valid = 1'b1;
    tick();
    p0 = cyc;
    in_valid = 1'b0;
    exp_q.push_back(8'hA1);
    while (cyc < p0 + 4) tick();
    in_data = 8'hB2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(8'hB2);
    while (cyc < p0 + FRAME) tick();
    n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL stop_pre: got %0d required 1", fifo_count); end
    in_data = 8'hC3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(8'hC3);
    n_tests++; if (fifo_count !== 3'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stop_pushpop: count=%0d ready=%b required 1 1", fifo_count, in_ready); end
    wait_idle("stop");
    n_tests++;
    if (starts.size() != s0 + 3) begin
      n_fail++;
      $display("FAIL stop_frames: got %0d required 3", starts.size() - s0);
    end else begin
      n_tests++;
      if (starts[s0 + 1] - starts[s0] != FRAME || starts[s0 + 2] - starts[s0 + 1] != FRAME) begin
        n_fail++;
        $display("FAIL stop_gap: got %0d,%0d required %0d", starts[s0 + 1] - starts[s0], starts[s0 + 2] - starts[s0 + 1], FRAME);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_hold();
    test_reset_mid();
    test_push_at_stop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
